// File: rtl/vram_arb_if.sv
// vram_arb client/vram bundle: video fetch, host access and vram port.
// slave = arbiter side, master = clients plus memory side.
interface vram_arb_if;
   logic        vid_sel;
   logic [15:0] vid_addr;
   logic        vid_stall;
   logic        vid_data_valid;
   logic [15:0] vid_data;
   logic        host_req;
   logic        host_wr;
   logic [15:0] host_addr;
   logic [15:0] host_data_in;
   logic        host_busy;
   logic        host_ack;
   logic [15:0] host_rd_data;
   logic        vram_sel;
   logic        vram_wr_en;
   logic [15:0] vram_addr;
   logic [15:0] vram_data_in;
   logic [15:0] vram_data_out;

   modport slave (
      input  vid_sel, vid_addr,
      input  host_req, host_wr, host_addr, host_data_in,
      input  vram_data_out,
      output vid_stall, vid_data_valid, vid_data,
      output host_busy, host_ack, host_rd_data,
      output vram_sel, vram_wr_en, vram_addr, vram_data_in
   );

   modport master (
      output vid_sel, vid_addr,
      output host_req, host_wr, host_addr, host_data_in,
      output vram_data_out,
      input  vid_stall, vid_data_valid, vid_data,
      input  host_busy, host_ack, host_rd_data,
      input  vram_sel, vram_wr_en, vram_addr, vram_data_in
   );
endinterface

// File: rtl/vram_arb.sv
// Video/host arbiter in front of the single-port 64Kx16 vram.
// Optional host starvation guard: define VRAM_ARB_STARVE_GUARD_EN.
module vram_arb #(
   parameter int STARVE_LIMIT = 8
) (
   input logic       clk,
   input logic       reset_n,
   vram_arb_if.slave bus
);

   typedef enum logic [1:0] {IDLE, PEND, DATA, ACK} state_t;

   state_t      state;
   logic        lat_wr;
   logic [15:0] lat_addr;
   logic [15:0] lat_data;
   logic        busy_q;
   logic        ack_q;
   logic        vdv_q;
   logic [15:0] rd_q;
   logic        force_host;
   logic        vid_gnt;
   logic        host_gnt;

   // Out-of-range limit only leaves this marker scope in the hierarchy
   if (STARVE_LIMIT < 2 || STARVE_LIMIT > 255) begin : g_bad_starve_limit
   end

`ifdef VRAM_ARB_STARVE_GUARD_EN
   logic [7:0] starve_cnt;

   assign force_host = (state == PEND) &&
                       (starve_cnt == 8'(STARVE_LIMIT));
   assign bus.vid_stall = reset_n && bus.vid_sel && force_host;

   always_ff @(posedge clk) begin
      if (!reset_n)
         starve_cnt <= '0;
      else if (host_gnt || state != PEND)
         starve_cnt <= '0;
      else if (bus.vid_sel)
         starve_cnt <= starve_cnt + 8'd1;
   end
`else
   assign force_host    = 1'b0;
   assign bus.vid_stall = 1'b0;
`endif

   assign vid_gnt  = reset_n && bus.vid_sel && !force_host;
   assign host_gnt = reset_n && (state == PEND) &&
                     (!bus.vid_sel || force_host);

   assign bus.vram_sel     = vid_gnt || host_gnt;
   assign bus.vram_wr_en   = host_gnt && lat_wr;
   assign bus.vram_addr    = vid_gnt ? bus.vid_addr : lat_addr;
   assign bus.vram_data_in = lat_data;

   assign bus.vid_data       = bus.vram_data_out;
   assign bus.vid_data_valid = vdv_q;
   assign bus.host_busy      = busy_q;
   assign bus.host_ack       = ack_q;
   assign bus.host_rd_data   = rd_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         busy_q   <= 1'b0;
         ack_q    <= 1'b0;
         vdv_q    <= 1'b0;
         rd_q     <= '0;
         lat_wr   <= 1'b0;
         lat_addr <= '0;
         lat_data <= '0;
      end else begin
         vdv_q <= vid_gnt;
         unique case (state)
            IDLE: begin
               if (bus.host_req) begin
                  lat_wr   <= bus.host_wr;
                  lat_addr <= bus.host_addr;
                  lat_data <= bus.host_data_in;
                  busy_q   <= 1'b1;
                  state    <= PEND;
               end
            end
            PEND: begin
               if (host_gnt)
                  state <= DATA;
            end
            DATA: begin
               // vram_data_out still holds the host read here
               if (!lat_wr)
                  rd_q <= bus.vram_data_out;
               ack_q <= 1'b1;
               state <= ACK;
            end
            ACK: begin
               ack_q  <= 1'b0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vram_arb.sv
// Bench for vram_arb: vram memory model plus timestamp reference model.
// Directed scenarios followed by a randomized run.
module tb_vram_arb;

   localparam int LIMIT = 8;

   logic clk = 1'b0;
   logic reset_n;

   vram_arb_if bus ();

   vram_arb #(.STARVE_LIMIT(LIMIT)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   logic [15:0] mem     [0:65535];
   logic [15:0] ref_mem [0:65535];

   always @(posedge clk) begin
      if (bus.vram_sel === 1'b1) begin
         if (bus.vram_wr_en === 1'b1)
            mem[bus.vram_addr] <= bus.vram_data_in;
         else
            bus.vram_data_out <= mem[bus.vram_addr];
      end
   end

   int checks   = 0;
   int failures = 0;
   int obs_wr   = 0;

   // Reference model: host transaction tracked by timestamps
   int          m_cyc  = 0;
   int          m_gcyc = -100;
   bit          m_pend = 1'b0;
   int          m_blk  = 0;
   bit          m_wr   = 1'b0;
   logic [15:0] m_addr = '0;
   logic [15:0] m_data = '0;
   logic [15:0] m_hval = '0;
   logic [15:0] m_rd   = '0;
   bit          m_vdv  = 1'b0;
   logic [15:0] m_vdata = '0;

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit rst, input bit vs,
                       input logic [15:0] va, input bit hr,
                       input bit hw, input logic [15:0] ha,
                       input logic [15:0] hd);
      bit busy_e, ack_e, frc, hg, vg;
      reset_n          = rst;
      bus.vid_sel      = vs;
      bus.vid_addr     = va;
      bus.host_req     = hr;
      bus.host_wr      = hw;
      bus.host_addr    = ha;
      bus.host_data_in = hd;
      @(negedge clk);
      busy_e = m_pend || (m_cyc <= m_gcyc + 2);
      ack_e  = (m_cyc == m_gcyc + 2);
      frc    = 1'b0;
`ifdef VRAM_ARB_STARVE_GUARD_EN
      frc = rst && m_pend && vs && (m_blk == LIMIT);
`endif
      hg = rst && m_pend && (!vs || frc);
      vg = rst && vs && !frc;
      chk("host_busy", 16'(bus.host_busy), 16'(busy_e));
      chk("host_ack", 16'(bus.host_ack), 16'(ack_e));
      chk("host_rd_data", bus.host_rd_data, m_rd);
      chk("vram_sel", 16'(bus.vram_sel), 16'(hg || vg));
      chk("vram_wr_en", 16'(bus.vram_wr_en), 16'(hg && m_wr));
      chk("vid_stall", 16'(bus.vid_stall), 16'(frc));
      chk("vid_data_valid", 16'(bus.vid_data_valid), 16'(m_vdv));
      if (m_vdv)
         chk("vid_data", bus.vid_data, m_vdata);
      if (hg || vg)
         chk("vram_addr", bus.vram_addr, vg ? va : m_addr);
      if (hg && m_wr)
         chk("vram_data_in", bus.vram_data_in, m_data);
      if (bus.vram_wr_en === 1'b1)
         obs_wr++;
      if (rst && m_cyc == m_gcyc + 1 && !m_wr)
         m_rd = m_hval;
      if (hg) begin
         m_gcyc = m_cyc;
         m_pend = 1'b0;
         if (m_wr)
            ref_mem[m_addr] = m_data;
         else
            m_hval = ref_mem[m_addr];
      end else if (rst && m_pend && vs) begin
         m_blk++;
      end
      m_vdv = vg;
      if (vg)
         m_vdata = ref_mem[va];
      if (rst && !busy_e && hr) begin
         m_pend = 1'b1;
         m_blk  = 0;
         m_wr   = hw;
         m_addr = ha;
         m_data = hd;
      end
      if (!rst) begin
         m_pend = 1'b0;
         m_gcyc = -100;
         m_blk  = 0;
         m_rd   = '0;
         m_vdv  = 1'b0;
      end
      m_cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(1, 0, 16'h0, 0, 0, 16'h0, 16'h0);
   endtask

   initial begin
      logic [15:0] orig;
      int          wr0;
      int          diffs;
      for (int i = 0; i < 65536; i++) begin
         mem[i]     = 16'($urandom);
         ref_mem[i] = mem[i];
      end
      reset_n          = 1'b0;
      bus.vid_sel      = 1'b0;
      bus.vid_addr     = '0;
      bus.host_req     = 1'b0;
      bus.host_wr      = 1'b0;
      bus.host_addr    = '0;
      bus.host_data_in = '0;
      @(posedge clk);
      #1;
      step(0, 1, 16'h0010, 1, 1, 16'h0011, 16'h0022);
      step(0, 0, 16'h0, 0, 0, 16'h0, 16'h0);
      idle(2);

      // Idle host write then read back
      step(1, 0, 16'h0, 1, 1, 16'h1234, 16'hBEEF);
      idle(4);
      step(1, 0, 16'h0, 1, 0, 16'h1234, 16'h0);
      idle(3);
      chk("rd_beef", bus.host_rd_data, 16'hBEEF);
      idle(1);

      // Contention: five video reads hold off a host read
      step(1, 0, 16'h0, 1, 0, 16'h4000, 16'h0);
      for (int i = 0; i < 5; i++)
         step(1, 1, 16'(i), 0, 0, 16'h0, 16'h0);
      idle(4);

      // Back-to-back host read then video read
      step(1, 0, 16'h0, 1, 0, 16'h8001, 16'h0);
      idle(1);
      step(1, 1, 16'hC002, 0, 0, 16'h0, 16'h0);
      idle(3);

      // Starvation window: video held high for 100 cycles
      wr0 = obs_wr;
      step(1, 0, 16'h0, 1, 1, 16'h3333, 16'h7777);
      for (int i = 0; i < 100; i++)
         step(1, 1, 16'($urandom), 0, 0, 16'h0, 16'h0);
`ifdef VRAM_ARB_STARVE_GUARD_EN
      chk("starve_wr_count", 16'(obs_wr - wr0), 16'd1);
`else
      chk("starve_wr_count", 16'(obs_wr - wr0), 16'd0);
`endif
      idle(4);

      // Reset while the host write is pending
      orig = ref_mem[16'h5555];
      step(1, 0, 16'h0, 1, 1, 16'h5555, 16'hAAAA);
      step(1, 1, 16'h0100, 0, 0, 16'h0, 16'h0);
      step(0, 1, 16'h0101, 0, 0, 16'h0, 16'h0);
      idle(5);
      chk("reset_mem_kept", mem[16'h5555], orig);

      // Request held across a whole transaction
      wr0 = obs_wr;
      for (int i = 0; i < 4; i++)
         step(1, 0, 16'h0, 1, 1, 16'h2222, 16'h1111);
      idle(5);
      chk("held_req_one_wr", 16'(obs_wr - wr0), 16'd1);

      // Randomized traffic
      for (int i = 0; i < 1500; i++)
         step(($urandom_range(149) != 0), ($urandom_range(1) == 1),
              {12'hA50, 4'($urandom)}, ($urandom_range(2) == 0),
              ($urandom_range(1) == 1), {12'hA50, 4'($urandom)},
              16'($urandom));
      idle(6);

      diffs = 0;
      for (int i = 0; i < 65536; i++)
         if (mem[i] !== ref_mem[i])
            diffs++;
      chk("mem_contents", 16'(diffs), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
